// File: rtl/cmd_issue_ctrl_pkg.sv
// Shared definitions for the command issue sequencer: command indices, FSM encoding, default tick counts.
// Default tick counts follow `CLK_FREQ (Hz), 50 MHz when not supplied by the build.
`ifndef CLK_FREQ
`define CLK_FREQ 50_000_000
`endif

package cmd_issue_ctrl_pkg;

    localparam int unsigned NUM_CMDS = 3;
    localparam int unsigned CMD_SR   = 0;
    localparam int unsigned CMD_DPR  = 1;
    localparam int unsigned CMD_CCW  = 2;

    localparam int unsigned CLK_FREQ_HZ = `CLK_FREQ;

    // 40 us reply window and 200 us decision wait (the latter outlasts the 100 us emergency delay)
    localparam int unsigned REPLY_WAIT_TICKS_DEF = CLK_FREQ_HZ / 25_000 - 1;
    localparam int unsigned DECIDE_TICKS_DEF     = CLK_FREQ_HZ / 5_000 - 1;
    localparam int unsigned MAX_REPEATS_DEF      = 2;

    typedef logic [NUM_CMDS-1:0] cmd_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_TX_WAIT,
        ST_REPLY,
        ST_DECIDE
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cmd_issue_ctrl_arb.sv
// Lowest-index-wins one-hot picker over the pending command bits (SR > DPR > CCW).
module cmd_prio_arb
    import cmd_issue_ctrl_pkg::*;
(
    input  cmd_vec_t pending,
    output cmd_vec_t grant_c
);

    // Two's-complement trick isolates the lowest set bit
    assign grant_c = pending & (~pending + cmd_vec_t'(1));

endmodule

// File: rtl/cmd_issue_ctrl.sv
// Command issue sequencer: arbitrates SR/DPR/CCW, starts the transmitter, opens the reply window
// and handles repeat / source-toggle decisions. Optional macro CMD_AUTO_TOGGLE_EN.
module cmd_issue_ctrl
    import cmd_issue_ctrl_pkg::*;
#(
    parameter int unsigned REPLY_WAIT_TICKS = REPLY_WAIT_TICKS_DEF,
    parameter int unsigned DECIDE_TICKS     = DECIDE_TICKS_DEF,
    parameter int unsigned MAX_REPEATS      = MAX_REPEATS_DEF
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_CMDS-1:0] cmd_reqs,
    input  logic [NUM_CMDS-1:0] repeat_reqs,
    input  logic [NUM_CMDS-1:0] toggle_com_src_reqs,
    input  logic                tx_busy,
    output logic                tx_start,
    output logic [NUM_CMDS-1:0] tx_cmd_sel,
    output logic                com_src,
    output logic [NUM_CMDS-1:0] delays_after_cmds_for_reply,
    output logic [NUM_CMDS-1:0] cmd_done,
    output logic [NUM_CMDS-1:0] cmd_failed,
    output logic                busy
);

    localparam int unsigned CNT_W   = max_u(2, $clog2(max_u(REPLY_WAIT_TICKS, DECIDE_TICKS) + 1));
    localparam int unsigned RETRY_W = max_u(1, $clog2(MAX_REPEATS + 1));

    localparam logic [CNT_W-1:0]   REPLY_LAST  = CNT_W'(REPLY_WAIT_TICKS);
    localparam logic [CNT_W-1:0]   DECIDE_LAST = CNT_W'(DECIDE_TICKS);
    localparam logic [CNT_W-1:0]   TXW_LAST    = CNT_W'(3);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_REPEATS);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry, retry_nxt;
    cmd_vec_t           pending, pending_nxt;
    cmd_vec_t           active, active_nxt;
    cmd_vec_t           grant, clr;
    cmd_vec_t           done_nxt, failed_nxt;
    logic               src_nxt;
    logic               seen_busy, seen_busy_nxt;
    logic               rep_hit, tog_hit;
`ifdef CMD_AUTO_TOGGLE_EN
    logic               auto_toggled, auto_toggled_nxt;
`endif

    cmd_prio_arb u_arb (
        .pending (pending),
        .grant_c (grant)
    );

    assign rep_hit = |(repeat_reqs & active);
    assign tog_hit = |(toggle_com_src_reqs & active);

    // Next-state, counters and decision logic
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        retry_nxt     = retry;
        active_nxt    = active;
        src_nxt       = com_src;
        seen_busy_nxt = seen_busy;
        done_nxt      = '0;
        failed_nxt    = '0;
        clr           = '0;
`ifdef CMD_AUTO_TOGGLE_EN
        auto_toggled_nxt = auto_toggled;
`endif
        case (state)
            ST_IDLE: begin
                if (|pending) begin
                    active_nxt = grant;
                    clr        = grant;
                    retry_nxt  = '0;
                    state_nxt  = ST_START;
`ifdef CMD_AUTO_TOGGLE_EN
                    auto_toggled_nxt = 1'b0;
`endif
                end
            end
            ST_START: begin
                cnt_nxt       = '0;
                seen_busy_nxt = tx_busy;
                state_nxt     = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                seen_busy_nxt = seen_busy | tx_busy;
                // Falling edge of tx_busy, or the transmitter never reacted within 4 cycles
                if (!tx_busy && (seen_busy || cnt == TXW_LAST)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_REPLY;
                end else if (!seen_busy) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_REPLY: begin
                if (cnt == REPLY_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_DECIDE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_DECIDE: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (tog_hit) begin
                    src_nxt   = ~com_src;
                    retry_nxt = '0;
                    state_nxt = ST_START;
                end else if (rep_hit) begin
                    if (retry < RETRY_MAX) begin
                        retry_nxt = retry + RETRY_W'(1);
                        state_nxt = ST_START;
`ifdef CMD_AUTO_TOGGLE_EN
                    end else if (!auto_toggled) begin
                        auto_toggled_nxt = 1'b1;
                        src_nxt          = ~com_src;
                        retry_nxt        = '0;
                        state_nxt        = ST_START;
`endif
                    end else begin
                        failed_nxt = active;
                        state_nxt  = ST_IDLE;
                    end
                end else if (cnt == DECIDE_LAST) begin
                    done_nxt  = active;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A new request on the bit being latched survives, so it is issued again later
        pending_nxt = (pending & ~clr) | cmd_reqs;
    end

    // State and registered outputs, aligned with the state they describe
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state                       <= ST_IDLE;
            cnt                         <= '0;
            retry                       <= '0;
            pending                     <= '0;
            active                      <= '0;
            seen_busy                   <= 1'b0;
            com_src                     <= 1'b0;
            tx_start                    <= 1'b0;
            tx_cmd_sel                  <= '0;
            delays_after_cmds_for_reply <= '0;
            cmd_done                    <= '0;
            cmd_failed                  <= '0;
            busy                        <= 1'b0;
        end else begin
            state                       <= state_nxt;
            cnt                         <= cnt_nxt;
            retry                       <= retry_nxt;
            pending                     <= pending_nxt;
            active                      <= active_nxt;
            seen_busy                   <= seen_busy_nxt;
            com_src                     <= src_nxt;
            tx_start                    <= (state_nxt == ST_START);
            tx_cmd_sel                  <= (state_nxt != ST_IDLE) ? active_nxt : '0;
            delays_after_cmds_for_reply <= (state_nxt == ST_REPLY) ? active_nxt : '0;
            cmd_done                    <= done_nxt;
            cmd_failed                  <= failed_nxt;
            busy                        <= (state_nxt != ST_IDLE);
        end
    end

`ifdef CMD_AUTO_TOGGLE_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) auto_toggled <= 1'b0;
        else        auto_toggled <= auto_toggled_nxt;
    end
`endif

endmodule
